// File: rtl/maze_carver_dfs_if.sv
// maze_carver_dfs_if
//   Bundles the control and result signals of maze_carver_dfs.
//   master : the requester (drives start / start_x / start_y, observes results)
//   slave  : the carver (drives busy, done, curr_x, curr_y, cells_carved,
//            maze_data and the debug state code)
//
//   Handshake: start is a single-cycle request. It is accepted on a rising
//   clk edge only while the carver is idle or done (busy=0); a start seen
//   while busy=1 is dropped. start_x/start_y are sampled on the accepting
//   edge. done stays high, with maze_data stable, until the next accepted
//   start.
interface maze_carver_dfs_if #(
    parameter int MAZE_W = 16,
    parameter int MAZE_H = 16
);
    localparam int XW = $clog2(MAZE_W);
    localparam int YW = $clog2(MAZE_H);
    localparam int GW = 2 * MAZE_W + 1;
    localparam int GH = 2 * MAZE_H + 1;
    localparam int NC = MAZE_W * MAZE_H;
    localparam int CW = $clog2(NC + 1);

    logic               start;
    logic [XW-1:0]      start_x;
    logic [YW-1:0]      start_y;
    logic               busy;
    logic               done;
    logic [XW-1:0]      curr_x;
    logic [YW-1:0]      curr_y;
    logic [CW-1:0]      cells_carved;
    logic [GW*GH-1:0]   maze_data;
    logic [1:0]         dbg_state;   // 0=IDLE 1=CLEAR 2=CARVE 3=DONE

    modport master (
        output start, start_x, start_y,
        input  busy, done, curr_x, curr_y, cells_carved, maze_data, dbg_state
    );

    modport slave (
        input  start, start_x, start_y,
        output busy, done, curr_x, curr_y, cells_carved, maze_data, dbg_state
    );
endinterface

// File: rtl/maze_carver_dfs.sv
// maze_carver_dfs
//   Randomised depth-first-search maze generator. The maze is a grid of
//   MAZE_W x MAZE_H cells held as a (2*MAZE_W+1) x (2*MAZE_H+1) tile bitmap
//   (1=open, 0=wall). Cell (cx,cy) is tile (2cx+1, 2cy+1); the tile between
//   two adjacent cells is their shared wall. One carve step per cycle:
//   either advance into a random unvisited neighbour (pushing the current
//   cell) or pop back one cell. The result is a spanning tree of NC cells
//   with 2*NC-1 open tiles.
//
//   Ports
//     clk    : clock, rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : maze_carver_dfs_if.slave
//              start/start_x/start_y in; busy, done, curr_x, curr_y,
//              cells_carved, maze_data, dbg_state out
module maze_carver_dfs #(
    parameter int          MAZE_W    = 16,
    parameter int          MAZE_H    = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic clk,
    input  logic rst_n,
    maze_carver_dfs_if.slave bus
);
    localparam int XW  = $clog2(MAZE_W);
    localparam int YW  = $clog2(MAZE_H);
    localparam int GW  = 2 * MAZE_W + 1;
    localparam int GH  = 2 * MAZE_H + 1;
    localparam int NC  = MAZE_W * MAZE_H;
    localparam int CW  = $clog2(NC + 1);
    localparam int TN  = GW * GH;          // tiles in the bitmap
    localparam int TW  = $clog2(TN);       // tile index width
    localparam int SD  = NC - 1;           // stack depth
    localparam int SPW = $clog2(SD);       // stack address width
    localparam int SW  = XW + YW;          // stack entry {x,y}

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        CARVE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [TN-1:0]   maze_q;
    logic [XW-1:0]   cx_q, sx_q, sx_in;
    logic [YW-1:0]   cy_q, sy_q, sy_in;
    logic [CW-1:0]   sp_q, sp_m1;
    logic [CW-1:0]   carved_q;
    logic [SW-1:0]   stack_mem [SD];
    logic [SW-1:0]   pop_w;
    logic [SPW-1:0]  pop_i;

    // neighbour search results
    logic            found;
    logic [XW-1:0]   nxt_x, cand_x;
    logic [YW-1:0]   nxt_y, cand_y;
    logic [1:0]      dir;
    logic            in_b;
    int              step, cur_t, probe_t;
    logic [TW-1:0]   wall_i, tgt_i, probe_i, start_i;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
    always_comb begin
        lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
    end

    // Out-of-range start coordinates fall back to column/row 0.
    always_comb begin
        sx_in = (32'(bus.start_x) >= 32'(MAZE_W)) ? '0 : bus.start_x;
        sy_in = (32'(bus.start_y) >= 32'(MAZE_H)) ? '0 : bus.start_y;
    end

    always_comb begin
        start_i = TW'((2 * int'(sx_q) + 1) + GW * (2 * int'(sy_q) + 1));
    end

    // Probe the four directions starting at lfsr[1:0]; the first one that is
    // in bounds and whose target tile is still a wall wins.
    always_comb begin
        cur_t   = (2 * int'(cx_q) + 1) + GW * (2 * int'(cy_q) + 1);
        found   = 1'b0;
        nxt_x   = cx_q;
        nxt_y   = cy_q;
        wall_i  = TW'(cur_t);
        tgt_i   = TW'(cur_t);
        dir     = 2'd0;
        in_b    = 1'b0;
        cand_x  = cx_q;
        cand_y  = cy_q;
        step    = 0;
        probe_t = cur_t;
        probe_i = TW'(cur_t);
        for (int i = 0; i < 4; i++) begin
            dir    = lfsr_q[1:0] + 2'(i);
            cand_x = cx_q;
            cand_y = cy_q;
            case (dir)
                2'd0: begin
                    in_b   = (cy_q != '0);
                    cand_y = cy_q - YW'(1);
                    step   = -GW;
                end
                2'd1: begin
                    in_b   = (32'(cx_q) < 32'(MAZE_W - 1));
                    cand_x = cx_q + XW'(1);
                    step   = 1;
                end
                2'd2: begin
                    in_b   = (32'(cy_q) < 32'(MAZE_H - 1));
                    cand_y = cy_q + YW'(1);
                    step   = GW;
                end
                default: begin
                    in_b   = (cx_q != '0);
                    cand_x = cx_q - XW'(1);
                    step   = -1;
                end
            endcase
            // Only dereference the bitmap at a legal tile index.
            probe_t = in_b ? (cur_t + 2 * step) : cur_t;
            probe_i = TW'(probe_t);
            if (!found && in_b && !maze_q[probe_i]) begin
                found  = 1'b1;
                nxt_x  = cand_x;
                nxt_y  = cand_y;
                wall_i = TW'(cur_t + step);
                tgt_i  = probe_i;
            end
        end
    end

    // Top of stack; the guard keeps the address in range when empty.
    always_comb begin
        sp_m1 = sp_q - CW'(1);
        pop_i = (sp_q == '0) ? '0 : sp_m1[SPW-1:0];
        pop_w = stack_mem[pop_i];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (bus.start) state_d = CLEAR;
            CLEAR: state_d = CARVE;
            CARVE: if (!found && (sp_q == '0)) state_d = DONE;
            DONE:  if (bus.start) state_d = CLEAR;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lfsr_q   <= LFSR_SEED;
            maze_q   <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            sx_q     <= '0;
            sy_q     <= '0;
            sp_q     <= '0;
            carved_q <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        sx_q <= sx_in;
                        sy_q <= sy_in;
                    end
                end
                CLEAR: begin
                    maze_q          <= '0;
                    maze_q[start_i] <= 1'b1;
                    cx_q            <= sx_q;
                    cy_q            <= sy_q;
                    sp_q            <= '0;
                    carved_q        <= CW'(1);
                end
                CARVE: begin
                    if (found) begin
                        maze_q[wall_i] <= 1'b1;
                        maze_q[tgt_i]  <= 1'b1;
                        cx_q           <= nxt_x;
                        cy_q           <= nxt_y;
                        sp_q           <= sp_q + CW'(1);
                        carved_q       <= carved_q + CW'(1);
                    end else if (sp_q != '0) begin
                        cx_q <= pop_w[SW-1:YW];
                        cy_q <= pop_w[YW-1:0];
                        sp_q <= sp_m1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stack storage carries no reset: only entries below sp_q are ever read,
    // and sp_q itself is reset.
    always_ff @(posedge clk) begin
        if (state_q == CARVE && found) begin
            stack_mem[sp_q[SPW-1:0]] <= {cx_q, cy_q};
        end
    end

    assign bus.busy         = (state_q == CLEAR) || (state_q == CARVE);
    assign bus.done         = (state_q == DONE);
    assign bus.curr_x       = cx_q;
    assign bus.curr_y       = cy_q;
    assign bus.cells_carved = carved_q;
    assign bus.maze_data    = maze_q;
    assign bus.dbg_state    = state_q;
endmodule

// File: doc/maze_carver_dfs.md
MAZE_CARVER_DFS -- requirements
Module: maze_carver_dfs

Interface
REQ-001 SHALL have parameter MAZE_W, default 16, maze width in cells (legal range 2..64).
REQ-002 SHALL have parameter MAZE_H, default 16, maze height in cells (legal range 2..64).
REQ-003 SHALL have parameter LFSR_SEED, default 16'hACE1, LFSR reset value (must be nonzero).
REQ-004 Derived widths SHALL be: XW=$clog2(MAZE_W), YW=$clog2(MAZE_H), GW=2*MAZE_W+1, GH=2*MAZE_H+1, NC=MAZE_W*MAZE_H, CW=$clog2(NC+1).
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port start  input  1  single-cycle request to begin a new maze.
REQ-008 SHALL have port start_x  input  XW  starting cell column, sampled when start is accepted.
REQ-009 SHALL have port start_y  input  YW  starting cell row, sampled when start is accepted.
REQ-010 SHALL have port busy  output  1  high while in CLEAR or CARVE.
REQ-011 SHALL have port done  output  1  high while in DONE.
REQ-012 SHALL have port curr_x  output  XW  current carving cell column.
REQ-013 SHALL have port curr_y  output  YW  current carving cell row.
REQ-014 SHALL have port cells_carved  output  CW  count of visited cells.
REQ-015 SHALL have port maze_data  output  GW*GH  tile bitmap (1=open, 0=wall); tile (tx,ty) is at bit tx+GW*ty.

Function
REQ-016 Cell (cx,cy) SHALL map to tile (2cx+1, 2cy+1); the wall between adjacent cells SHALL be the tile midway between them; border tiles SHALL never open.
REQ-017 A cell SHALL count as visited when its tile bit is 1.
REQ-018 A 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1) SHALL advance every cycle in every state.
REQ-019 The random direction SHALL be taken from lfsr[1:0], with 0=N(y-1), 1=E(x+1), 2=S(y+1), 3=W(x-1).
REQ-020 FSM states SHALL be IDLE, CLEAR, CARVE and DONE.
REQ-021 In IDLE or DONE, start=1 SHALL move the FSM to CLEAR and latch the start coordinates; start SHALL be ignored in CLEAR and CARVE.
REQ-022 A start_x >= MAZE_W SHALL be replaced by 0; a start_y >= MAZE_H SHALL be replaced by 0.
REQ-023 CLEAR SHALL last 1 cycle and perform all of: zero maze_data; open the start cell tile; set curr to the start cell; set stack pointer to 0; set cells_carved=1; go to CARVE.
REQ-024 A neighbour SHALL be valid only if it is in bounds and unvisited.
REQ-025 The candidate order SHALL be d, d+1, d+2, d+3 (mod 4), where d = lfsr[1:0] in that cycle; the first valid candidate SHALL be chosen.
REQ-026 CARVE advance (a valid neighbour exists) SHALL, in one cycle: push curr; open the wall tile and target tile; set curr to target; increment cells_carved.
REQ-027 CARVE backtrack (no valid neighbour, stack nonempty) SHALL, in one cycle, pop the stack into curr with no bitmap change.
REQ-028 CARVE with no valid neighbour and an empty stack SHALL go to DONE.
REQ-029 The stack SHALL be NC-1 entries of {x,y} with a pointer of CW bits; overflow is impossible by construction.
REQ-030 CARVE SHALL last exactly 2*NC-1 cycles; done SHALL rise at cycle 2*NC+1 after the start-accept edge.
REQ-031 On finish, cells_carved SHALL equal NC and the open-tile count SHALL equal 2*NC-1 (spanning tree).
REQ-032 In DONE, maze_data SHALL hold stable until the next accepted start.

Reset
REQ-033 rst_n=0 SHALL immediately force: state=IDLE, busy=0, done=0, curr_x=0, curr_y=0, cells_carved=0, maze_data all 0, stack pointer=0, lfsr=LFSR_SEED.
REQ-034 Reset asserted mid-CARVE SHALL abort carving with no residual state; the first start after release SHALL behave as from power-up.

Verification
REQ-035 Reset: assert rst_n=0 mid-cycle -> all outputs zero without waiting for a clk edge; release and idle 10 cycles -> outputs remain zero.
REQ-036 MAZE_W=MAZE_H=2, start=(0,0) -> busy for 8 cycles; done at cycle 9; cells_carved=4; 7 open tiles, all at odd-odd or wall positions; border tiles 0.
REQ-037 Default 16x16, start=(5,9) -> done after 513 cycles; cells_carved=256; popcount(maze_data)=511; every cell reachable from (5,9) by BFS on the bitmap.
REQ-038 start pulsed during CARVE -> ignored: cycle count and final maze are identical to a run without the extra pulse.
REQ-039 MAZE_W=12 (non-power-of-2), start_x=13 -> start cell column treated as 0; curr_x never exceeds 11; done with cells_carved=12*MAZE_H.
REQ-040 Restart from DONE -> CLEAR zeroes the previous maze; the second maze differs (LFSR state advanced) and again satisfies REQ-031.
